// File: rtl/sorter_share_arbiter_if.sv
// Client-side bundle for the shared sorter: per-requester job handshake plus
// the tagged result stream returned to the requesters.
interface sorter_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) ();
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_data;
  logic                  resp_valid;
  logic [ID_W-1:0]       resp_id;
  logic [7:0]            resp_max;
  logic [7:0]            resp_second_max;
  logic [7:0]            resp_second_min;
  logic [7:0]            resp_min;

  modport master (
    output req_valid, req_data,
    input  req_ready, resp_valid, resp_id,
    input  resp_max, resp_second_max, resp_second_min, resp_min
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, resp_valid, resp_id,
    output resp_max, resp_second_max, resp_second_min, resp_min
  );
endinterface

// File: rtl/sorter_share_arbiter.sv
// Round-robin sharing of one 4-input byte sorter between NUM_REQ clients,
// with a latency-matched tag pipe that returns each result to its issuer.
module sorter_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 flush,
  sorter_share_arbiter_if.slave cli,
  output logic [7:0]           srt_a,
  output logic [7:0]           srt_b,
  output logic [7:0]           srt_c,
  output logic [7:0]           srt_d,
  input  logic [7:0]           srt_max,
  input  logic [7:0]           srt_second_max,
  input  logic [7:0]           srt_second_min,
  input  logic [7:0]           srt_min,
  output logic [ID_W+2:0]      in_flight,
  output logic                 idle,
  output logic [15:0]          issued_cnt
);
  localparam int unsigned NR  = NUM_REQ;
  localparam int          IFW = ID_W + 3;

  logic [ID_W-1:0]                 r_ptr;
  logic [31:0]                     r_srt;
  logic                            r_issue_v;
  logic [ID_W-1:0]                 r_issue_id;
  logic [LATENCY-1:0]              r_tag_v;
  logic [LATENCY-1:0][ID_W-1:0]    r_tag_id;
  logic                            r_resp_v;
  logic [ID_W-1:0]                 r_resp_id;
  logic [31:0]                     r_resp;
  logic [IFW-1:0]                  r_in_flight;
  logic [15:0]                     r_cnt;

  logic [NUM_REQ-1:0][31:0]        w_data;
  logic [NUM_REQ-1:0]              w_grant;
  logic [ID_W-1:0]                 w_gnt_id;
  logic                            w_found;
  logic                            w_hs;
  logic                            w_ret;
  logic [31:0]                     w_gnt_data;

  assign w_data = cli.req_data;

  // Search starts one past the last granted index so a persistent requester
  // cannot starve the others.
  always_comb begin : arb
    logic [ID_W-1:0] idx;
    idx      = '0;
    w_grant  = '0;
    w_gnt_id = '0;
    w_found  = 1'b0;
    if (enable && !rst && !flush) begin
      for (int unsigned k = 1; k <= NR; k++) begin
        idx = ID_W'((32'(r_ptr) + k) % NR);
        if (!w_found && cli.req_valid[idx]) begin
          w_found      = 1'b1;
          w_grant[idx] = 1'b1;
          w_gnt_id     = idx;
        end
      end
    end
  end

  assign w_hs       = w_found;
  assign w_gnt_data = w_data[w_gnt_id];
  assign w_ret      = r_tag_v[LATENCY-1] && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= ID_W'(NUM_REQ - 1);
      r_srt       <= '0;
      r_issue_v   <= 1'b0;
      r_issue_id  <= '0;
      r_tag_v     <= '0;
      r_tag_id    <= '0;
      r_resp_v    <= 1'b0;
      r_resp_id   <= '0;
      r_resp      <= '0;
      r_in_flight <= '0;
      r_cnt       <= '0;
    end else begin
      r_issue_v <= w_hs;
      if (w_hs) begin
        r_ptr      <= w_gnt_id;
        r_srt      <= w_gnt_data;
        r_issue_id <= w_gnt_id;
        r_cnt      <= r_cnt + 16'd1;
      end
      // Concatenate-and-truncate shifts the issue tag into stage 0.
      r_tag_v  <= LATENCY'({r_tag_v, r_issue_v});
      r_tag_id <= (LATENCY*ID_W)'({r_tag_id, r_issue_id});
      r_resp_v <= w_ret;
      if (w_ret) begin
        r_resp_id <= r_tag_id[LATENCY-1];
        r_resp    <= {srt_max, srt_second_max, srt_second_min, srt_min};
      end
      if (flush) begin
        r_issue_v   <= 1'b0;
        r_tag_v     <= '0;
        r_resp_v    <= 1'b0;
        r_in_flight <= '0;
      end else if (w_hs && !w_ret) begin
        r_in_flight <= r_in_flight + IFW'(1);
      end else if (!w_hs && w_ret) begin
        r_in_flight <= r_in_flight - IFW'(1);
      end
    end
  end

  assign cli.req_ready       = w_grant;
  assign cli.resp_valid      = r_resp_v;
  assign cli.resp_id         = r_resp_id;
  assign cli.resp_max        = r_resp[31:24];
  assign cli.resp_second_max = r_resp[23:16];
  assign cli.resp_second_min = r_resp[15:8];
  assign cli.resp_min        = r_resp[7:0];

  assign srt_a      = r_srt[7:0];
  assign srt_b      = r_srt[15:8];
  assign srt_c      = r_srt[23:16];
  assign srt_d      = r_srt[31:24];
  assign in_flight  = r_in_flight;
  assign idle       = (r_in_flight == '0) && !w_hs;
  assign issued_cnt = r_cnt;
endmodule

// File: tb/tb_sorter_share_arbiter.sv
// Bench for sorter_share_arbiter: behavioural sorter stub, queue-based job
// model, directed vector table, corner-case sequences and random traffic.
module tb_sorter_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LAT     = 3;

  logic clk = 1'b0;
  logic rst, enable, flush;
  logic [7:0] srt_a, srt_b, srt_c, srt_d;
  logic [7:0] srt_max, srt_second_max, srt_second_min, srt_min;
  logic [ID_W+2:0] in_flight;
  logic idle;
  logic [15:0] issued_cnt;

  sorter_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) ifc ();

  sorter_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .cli(ifc),
    .srt_a(srt_a), .srt_b(srt_b), .srt_c(srt_c), .srt_d(srt_d),
    .srt_max(srt_max), .srt_second_max(srt_second_max),
    .srt_second_min(srt_second_min), .srt_min(srt_min),
    .in_flight(in_flight), .idle(idle), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  // Descending sort of four bytes, packed {max, second_max, second_min, min}.
  function automatic logic [31:0] sort4(input logic [31:0] d);
    logic [7:0] b [4];
    logic [7:0] t;
    for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (b[j] < b[j+1]) begin t = b[j]; b[j] = b[j+1]; b[j+1] = t; end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  // Sorter stand-in: results appear LAT cycles after the operands.
  logic [31:0] sp [LAT];
  always @(posedge clk) begin
    sp[0] <= sort4({srt_d, srt_c, srt_b, srt_a});
    for (int i = 1; i < LAT; i++) sp[i] <= sp[i-1];
  end
  assign {srt_max, srt_second_max, srt_second_min, srt_min} = sp[LAT-1];

  typedef struct { int id; logic [31:0] res; int due; } job_t;
  typedef struct { int id; logic [31:0] data; logic [31:0] exp_res; } vec_t;

  job_t q[$];
  int cyc, m_ptr, m_rid;
  logic [15:0] m_cnt;
  logic [31:0] m_srt, m_res;
  logic [NUM_REQ-1:0] last_ready;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic [NUM_REQ-1:0] v, input logic en, input logic fl, input logic rs);
    ifc.req_valid = v;
    enable = en;
    flush  = fl;
    rst    = rs;
  endtask

  // One clock cycle: compare all outputs with the model, then advance it.
  task automatic step();
    int g;
    logic exp_rv;
    #1;
    g = -1;
    if (!rst && enable && !flush)
      for (int k = 1; k <= NUM_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NUM_REQ;
        if (g < 0 && ifc.req_valid[idx]) g = idx;
      end
    last_ready = ifc.req_ready;
    chk("req_ready", 32'(ifc.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    exp_rv = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_rv = 1'b1;
      m_rid  = q[0].id;
      m_res  = q[0].res;
      void'(q.pop_front());
    end
    chk("resp_valid", 32'(ifc.resp_valid), 32'(exp_rv));
    chk("resp_id", 32'(ifc.resp_id), 32'(m_rid));
    chk("resp_data", {ifc.resp_max, ifc.resp_second_max, ifc.resp_second_min, ifc.resp_min}, m_res);
    chk("srt_operands", {srt_d, srt_c, srt_b, srt_a}, m_srt);
    chk("in_flight", 32'(in_flight), 32'(q.size()));
    chk("idle", 32'(idle), 32'(q.size() == 0 && g < 0));
    chk("issued_cnt", 32'(issued_cnt), 32'(m_cnt));
    if (rst) begin
      q.delete();
      m_ptr = NUM_REQ - 1; m_cnt = '0; m_srt = '0; m_res = '0; m_rid = 0;
    end else if (flush) begin
      q.delete();
    end else if (g >= 0) begin
      job_t j;
      j.id  = g;
      j.res = sort4(ifc.req_data[32*g +: 32]);
      j.due = cyc + LAT + 2;
      q.push_back(j);
      m_ptr = g;
      m_cnt = m_cnt + 16'd1;
      m_srt = ifc.req_data[32*g +: 32];
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    drive('0, 1'b1, 1'b0, 1'b1);
    step();
  endtask

  task automatic drain(input int n);
    drive('0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  vec_t tbl [5];

  initial begin
    tbl[0] = '{0, 32'h0533F010, 32'hF0331005};
    tbl[1] = '{2, 32'h07070707, 32'h07070707};
    tbl[2] = '{1, 32'h00FF8001, 32'hFF800100};
    tbl[3] = '{3, 32'h12345678, 32'h78563412};
    tbl[4] = '{1, 32'hAAAA5555, 32'hAAAA5555};

    ifc.req_valid = '0;
    ifc.req_data  = '0;
    enable = 1'b0; flush = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc = 0; m_ptr = NUM_REQ - 1; m_rid = 0; m_cnt = '0; m_srt = '0; m_res = '0;

    // Directed single jobs: handshake, then result exactly LAT+2 cycles later.
    for (int v = 0; v < 5; v++) begin
      for (int r = 0; r < NUM_REQ; r++) ifc.req_data[32*r +: 32] = $urandom;
      ifc.req_data[32*tbl[v].id +: 32] = tbl[v].data;
      drive(4'(1 << tbl[v].id), 1'b1, 1'b0, 1'b0);
      step();
      drain(LAT + 1);
      #1;
      chk("vec_resp_valid", 32'(ifc.resp_valid), 32'd1);
      chk("vec_resp_id", 32'(ifc.resp_id), 32'(tbl[v].id));
      chk("vec_resp_data", {ifc.resp_max, ifc.resp_second_max, ifc.resp_second_min, ifc.resp_min},
          tbl[v].exp_res);
      drain(2);
    end

    // All requesters continuously valid: strict rotation, in_flight saturates.
    do_reset();
    for (int r = 0; r < NUM_REQ; r++) ifc.req_data[32*r +: 32] = $urandom;
    drive('1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_order", 32'(last_ready), 32'd1 << (i % NUM_REQ));
    end
    drive('0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("issued_cnt_8", 32'(issued_cnt), 32'd8);
    drain(LAT + 4);

    // Flush two in-flight jobs; pointer survives.
    do_reset();
    drive(4'b0011, 1'b1, 1'b0, 1'b0);
    step(); step();
    drive('0, 1'b1, 1'b1, 1'b0);
    step();
    drive('0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("flush_in_flight", 32'(in_flight), 32'd0);
    chk("flush_idle", 32'(idle), 32'd1);
    drain(LAT + 4);
    drive('1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("flush_rr_kept", 32'(ifc.req_ready), 32'b0100);
    step();
    drain(LAT + 4);

    // Enable low blocks grants but lets the in-flight job return.
    do_reset();
    drive(4'b0001, 1'b1, 1'b0, 1'b0);
    step();
    drive(4'b0010, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LAT + 3; i++) begin
      #1;
      chk("enable_low_ready", 32'(ifc.req_ready), 32'd0);
      step();
    end
    drive(4'b0010, 1'b1, 1'b0, 1'b0);
    #1;
    chk("enable_rise_grant", 32'(ifc.req_ready), 32'b0010);
    step();
    drain(LAT + 4);

    // Reset with three jobs in flight.
    do_reset();
    drive('1, 1'b1, 1'b0, 1'b0);
    step(); step(); step();
    drive('1, 1'b1, 1'b0, 1'b1);
    step();
    drive('0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rst_in_flight", 32'(in_flight), 32'd0);
    chk("rst_srt", {srt_d, srt_c, srt_b, srt_a}, 32'd0);
    chk("rst_issued_cnt", 32'(issued_cnt), 32'd0);
    drain(LAT + 4);
    drive('1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rst_first_grant", 32'(ifc.req_ready), 32'b0001);
    step();
    drain(LAT + 4);

    // Random traffic with occasional enable drops, flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      for (int r = 0; r < NUM_REQ; r++) ifc.req_data[32*r +: 32] = $urandom;
      drive(4'($urandom), ($urandom % 8) != 0, ($urandom % 32) == 0, ($urandom % 200) == 0);
      step();
    end
    drain(LAT + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
